degamma_lut_ctrl: RTL and testbench

DEGAMMA_LUT_CTRL -- requirements
Module: degamma_lut_ctrl

---
 rtl/degamma_lut_ctrl_pkg.sv | 22 ++
 rtl/level_to_pulse.sv | 30 +++
 rtl/degamma_lut_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_degamma_lut_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/degamma_lut_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// degamma_lut_ctrl_pkg
// Shared constants and types for the degamma LUT load/bank-swap controller.
//   DEG_DW       : LUT entry data width
//   TBL_DW       : per-table (A = even entries, B = odd entries) address width
//   LUT_ENTRIES  : entries per full table load; entry k covers input code 2k
//   lut_state_e  : controller FSM state encoding
// -----------------------------------------------------------------------------
package degamma_lut_ctrl_pkg;

  localparam int DEG_DW      = 12;
  localparam int TBL_DW      = 7;
  localparam int LUT_ENTRIES = 129;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2,
    ST_PEND = 2'd3
  } lut_state_e;

endpackage : degamma_lut_ctrl_pkg

// File: rtl/level_to_pulse.sv
// -----------------------------------------------------------------------------
// level_to_pulse
// Rising-edge detector for a level signal already in the clk domain.
//   clk   : clock
//   rstn  : asynchronous active-low reset (history cleared to 0)
//   level : input level
//   pulse : 1 while level=1 and the registered previous level=0
// -----------------------------------------------------------------------------
module level_to_pulse (
  input  logic clk,
  input  logic rstn,
  input  logic level,
  output logic pulse
);

  logic level_d_r;

  // One-cycle history of the level input.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level_d_r <= 1'b0;
    end else begin
      level_d_r <= level;
    end
  end

  // Same-cycle edge so consumers can act on the edge cycle itself.
  assign pulse = level & ~level_d_r;

endmodule : level_to_pulse

// File: rtl/degamma_lut_ctrl.sv
// -----------------------------------------------------------------------------
// degamma_lut_ctrl
// Loads a double-buffered degamma LUT from a host write stream and swaps the
// active bank on the frame sync after a commit.
//   clk, rstn            : clock, asynchronous active-low reset
//   vsync_in             : frame sync level
//   reg_degamma_en       : register-level enable, applied at frame start
//   load_start, commit   : one-cycle host control pulses
//   wr_valid/wr_ready/wr_data : host entry-write handshake
//   mem_we_a/mem_we_b    : shadow bank write enables (A = even, B = odd entries)
//   mem_adr, mem_wdata   : shadow bank write address / data
//   mem_wbank            : bank being written (always ~active_bank)
//   active_bank          : bank read by the pixel path
//   degamma_en_eff       : frame-aligned datapath enable
//   busy, swap_done, load_err : status
// -----------------------------------------------------------------------------
module degamma_lut_ctrl #(
  parameter int DEG_DW      = degamma_lut_ctrl_pkg::DEG_DW,
  parameter int TBL_DW      = degamma_lut_ctrl_pkg::TBL_DW,
  parameter int LUT_ENTRIES = degamma_lut_ctrl_pkg::LUT_ENTRIES
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              vsync_in,
  input  logic              reg_degamma_en,
  input  logic              load_start,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DEG_DW-1:0] wr_data,
  input  logic              commit,
  output logic              mem_we_a,
  output logic              mem_we_b,
  output logic [TBL_DW-1:0] mem_adr,
  output logic [DEG_DW-1:0] mem_wdata,
  output logic              mem_wbank,
  output logic              active_bank,
  output logic              degamma_en_eff,
  output logic              busy,
  output logic              swap_done,
  output logic              load_err
);

  import degamma_lut_ctrl_pkg::*;

  localparam int IDX_W = (LUT_ENTRIES > 1) ? $clog2(LUT_ENTRIES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LUT_ENTRIES - 1);

  lut_state_e       state_r, state_nxt_s;
  logic [IDX_W-1:0] idx_r, idx_nxt_s;
  logic             err_nxt_s;
  logic             swap_s;
  logic             vsync_rise_s;
  logic             wr_fire_s;

  level_to_pulse u_vsync_edge (
    .clk   (clk),
    .rstn  (rstn),
    .level (vsync_in),
    .pulse (vsync_rise_s)
  );

  // wr_ready is a registered copy of (state == LOAD), so this is the handshake.
  assign wr_fire_s = wr_valid & wr_ready;

  // Next-state, entry index, sticky error and swap request.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    err_nxt_s   = load_err;
    swap_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (load_start) begin
          state_nxt_s = ST_LOAD;
          idx_nxt_s   = {IDX_W{1'b0}};
          err_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // A commit on a partial table aborts the load without swapping.
        if (commit) begin
          state_nxt_s = ST_IDLE;
          err_nxt_s   = 1'b1;
        end else if (wr_fire_s) begin
          idx_nxt_s = idx_r + IDX_W'(1);
          if (idx_r == LAST_IDX) begin
            state_nxt_s = ST_FULL;
          end else begin
            state_nxt_s = ST_LOAD;
          end
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_FULL: begin
        if (load_start) begin
          state_nxt_s = ST_LOAD;
          idx_nxt_s   = {IDX_W{1'b0}};
        end else if (commit) begin
          // A vsync edge on the commit cycle is not seen here, so the swap
          // lands on the following edge.
          state_nxt_s = ST_PEND;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      ST_PEND: begin
        if (vsync_rise_s) begin
          state_nxt_s = ST_IDLE;
          swap_s      = 1'b1;
        end else begin
          state_nxt_s = ST_PEND;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        idx_nxt_s   = {IDX_W{1'b0}};
      end
    endcase
  end

  // FSM state, entry index and the status flags derived from next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r  <= ST_IDLE;
      idx_r    <= {IDX_W{1'b0}};
      load_err <= 1'b0;
      wr_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      idx_r    <= idx_nxt_s;
      load_err <= err_nxt_s;
      wr_ready <= (state_nxt_s == ST_LOAD);
      busy     <= (state_nxt_s != ST_IDLE);
    end
  end

  // Shadow-bank write port: one cycle behind the handshake, even/odd split.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_we_a  <= 1'b0;
      mem_we_b  <= 1'b0;
      mem_adr   <= {TBL_DW{1'b0}};
      mem_wdata <= {DEG_DW{1'b0}};
    end else begin
      mem_we_a <= wr_fire_s & ~idx_r[0];
      mem_we_b <= wr_fire_s &  idx_r[0];
      if (wr_fire_s) begin
        mem_adr   <= TBL_DW'(idx_r >> 1);
        mem_wdata <= wr_data;
      end else begin
        mem_adr   <= mem_adr;
        mem_wdata <= mem_wdata;
      end
    end
  end

  // Frame-aligned bank swap and enable update.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active_bank    <= 1'b0;
      swap_done      <= 1'b0;
      degamma_en_eff <= 1'b0;
    end else begin
      swap_done <= swap_s;
      if (swap_s) begin
        active_bank <= ~active_bank;
      end else begin
        active_bank <= active_bank;
      end
      if (vsync_rise_s) begin
        degamma_en_eff <= reg_degamma_en;
      end else begin
        degamma_en_eff <= degamma_en_eff;
      end
    end
  end

  assign mem_wbank = ~active_bank;

endmodule : degamma_lut_ctrl

// File: tb/tb_degamma_lut_ctrl.sv
// -----------------------------------------------------------------------------
// tb_degamma_lut_ctrl
// Directed stimulus with a scoreboard: expected shadow writes and bank swaps
// are queued when stimulus is issued; a negedge monitor pops and compares
// whenever the DUT presents a write enable or swap_done.
// -----------------------------------------------------------------------------
module tb_degamma_lut_ctrl;

  logic        clk;
  logic        rstn;
  logic        vsync_in;
  logic        reg_degamma_en;
  logic        load_start;
  logic        wr_valid;
  logic        wr_ready;
  logic [11:0] wr_data;
  logic        commit;
  logic        mem_we_a;
  logic        mem_we_b;
  logic [6:0]  mem_adr;
  logic [11:0] mem_wdata;
  logic        mem_wbank;
  logic        active_bank;
  logic        degamma_en_eff;
  logic        busy;
  logic        swap_done;
  logic        load_err;

  int checks   = 0;
  int failures = 0;

  // {we_b, adr, data}
  logic [19:0] wr_q[$];
  logic        swap_q[$];

  degamma_lut_ctrl dut (
    .clk            (clk),
    .rstn           (rstn),
    .vsync_in       (vsync_in),
    .reg_degamma_en (reg_degamma_en),
    .load_start     (load_start),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_data        (wr_data),
    .commit         (commit),
    .mem_we_a       (mem_we_a),
    .mem_we_b       (mem_we_b),
    .mem_adr        (mem_adr),
    .mem_wdata      (mem_wdata),
    .mem_wbank      (mem_wbank),
    .active_bank    (active_bank),
    .degamma_en_eff (degamma_en_eff),
    .busy           (busy),
    .swap_done      (swap_done),
    .load_err       (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_entries(input int n);
    logic [7:0]  k8;
    logic [11:0] d;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int k = 0; k < n; k++) begin
      k8 = 8'(k);
      d  = 12'(k * 31);
      wr_valid = 1'b1;
      wr_data  = d;
      wr_q.push_back({k8[0], k8[7:1], d});
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic vsync_edge();
    vsync_in = 1'b1;
    repeat (3) tick();
    vsync_in = 1'b0;
    repeat (3) tick();
  endtask

  task automatic random_valid_no_ready(input string name);
    for (int i = 0; i < 12; i++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_data  = 12'($urandom_range(0, 4095));
      tick();
      chk(name, {31'd0, wr_ready}, 32'd0);
    end
    wr_valid = 1'b0;
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from updates.
  always @(negedge clk) begin
    if (rstn) begin
      if (mem_we_a && mem_we_b) begin
        checks++;
        failures++;
        $display("FAIL we_both actual=11 required=not both");
      end
      if (mem_we_a || mem_we_b) begin
        checks++;
        if (wr_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write actual=we_b%0b adr=%0d data=%0h required=no write",
                   mem_we_b, mem_adr, mem_wdata);
        end else begin
          logic [19:0] e;
          e = wr_q.pop_front();
          if ({mem_we_b, mem_adr, mem_wdata} !== e) begin
            failures++;
            $display("FAIL write actual=%0h required=%0h", {mem_we_b, mem_adr, mem_wdata}, e);
          end
        end
      end
      if (swap_done) begin
        checks++;
        if (swap_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_swap actual=1 required=0");
        end else begin
          logic eb;
          eb = swap_q.pop_front();
          if (active_bank !== eb) begin
            failures++;
            $display("FAIL swap_bank actual=%0b required=%0b", active_bank, eb);
          end
        end
      end
    end
  end

  initial begin
    rstn = 1'b0; vsync_in = 1'b0; reg_degamma_en = 1'b0; load_start = 1'b0;
    wr_valid = 1'b0; wr_data = 12'd0; commit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_bank", {31'd0, active_bank}, 32'd0);
    chk("rst_wbank", {31'd0, mem_wbank}, 32'd1);
    chk("rst_we", {30'd0, mem_we_a, mem_we_b}, 32'd0);
    chk("rst_adr_data", {13'd0, mem_adr, mem_wdata}, 32'd0);
    rstn = 1'b1;
    tick();

    // Full load of 129 entries, commit, swap on vsync.
    load_entries(129);
    chk("last_we_a", {31'd0, mem_we_a}, 32'd1);
    chk("last_adr", {25'd0, mem_adr}, 32'd64);
    chk("last_data", {20'd0, mem_wdata}, 32'd3968);
    chk("full_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("full_busy", {31'd0, busy}, 32'd1);
    tick();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("pend_busy", {31'd0, busy}, 32'd1);
    chk("pend_bank", {31'd0, active_bank}, 32'd0);
    swap_q.push_back(1'b1);
    vsync_edge();
    chk("swap1_bank", {31'd0, active_bank}, 32'd1);
    chk("swap1_wbank", {31'd0, mem_wbank}, 32'd0);
    chk("swap1_idle", {31'd0, busy}, 32'd0);

    // Partial load then commit: error, no swap.
    load_entries(50);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("partial_err", {31'd0, load_err}, 32'd1);
    chk("partial_idle", {31'd0, busy}, 32'd0);
    chk("partial_ready", {31'd0, wr_ready}, 32'd0);
    vsync_edge();
    chk("partial_bank", {31'd0, active_bank}, 32'd1);
    chk("partial_err_sticky", {31'd0, load_err}, 32'd1);

    // Full load; writes held off in FULL; commit coincident with vsync edge.
    load_entries(129);
    chk("reload_err_clr", {31'd0, load_err}, 32'd0);
    random_valid_no_ready("full_hold_ready");
    commit = 1'b1;
    vsync_in = 1'b1;
    tick();
    commit = 1'b0;
    repeat (2) tick();
    vsync_in = 1'b0;
    tick();
    chk("coincident_no_swap", {31'd0, active_bank}, 32'd1);
    chk("coincident_busy", {31'd0, busy}, 32'd1);
    random_valid_no_ready("pend_hold_ready");
    swap_q.push_back(1'b0);
    vsync_edge();
    chk("swap2_bank", {31'd0, active_bank}, 32'd0);

    // Enable changes only at frame start.
    reg_degamma_en = 1'b1;
    repeat (5) tick();
    chk("en_midframe", {31'd0, degamma_en_eff}, 32'd0);
    vsync_edge();
    chk("en_at_vsync", {31'd0, degamma_en_eff}, 32'd1);
    reg_degamma_en = 1'b0;
    repeat (4) tick();
    chk("en_hold", {31'd0, degamma_en_eff}, 32'd1);

    // Reset in the middle of a load.
    load_entries(40);
    tick();
    rstn = 1'b0;
    #2;
    chk("mid_rst_ready", {31'd0, wr_ready}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_en", {31'd0, degamma_en_eff}, 32'd0);
    chk("mid_rst_we", {30'd0, mem_we_a, mem_we_b}, 32'd0);
    chk("mid_rst_adr_data", {13'd0, mem_adr, mem_wdata}, 32'd0);
    chk("mid_rst_status", {30'd0, swap_done, load_err}, 32'd0);
    chk("mid_rst_bank", {30'd0, active_bank, mem_wbank}, 32'd1);
    tick();
    rstn = 1'b1;
    tick();
    vsync_edge();
    vsync_edge();
    chk("post_rst_bank", {31'd0, active_bank}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    tick();
    chk("wr_q_drained", wr_q.size(), 32'd0);
    chk("swap_q_drained", swap_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_degamma_lut_ctrl
